// File: rtl/svm_pkg.sv
// Shared constants and FSM state encoding for the SVM MAC sequencer.
package svm_pkg;

  localparam int SVM_NBITS     = 8;
  localparam int SVM_NPARALLEL = 4;
  localparam int SVM_NFEATURES = 16;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } svm_state_e;

endpackage

// File: rtl/multiply_quantize.sv
// Per-lane signed weight x feature multiply, keeping the upper NBITS of the
// 2*NBITS product (arithmetic shift right by NBITS).
module multiply_quantize #(
  parameter int NBITS     = 8,
  parameter int NPARALLEL = 4
) (
  input  logic [NPARALLEL-1:0][NBITS-1:0] weights,
  input  logic signed [NBITS-1:0]         feature,
  output logic [NPARALLEL-1:0][NBITS-1:0] quant
);

  logic signed [2*NBITS-1:0] feature_ext;

  assign feature_ext = {{NBITS{feature[NBITS-1]}}, feature};

  for (genvar p = 0; p < NPARALLEL; p++) begin : g_lane
    logic signed [2*NBITS-1:0] weight_ext;
    logic signed [2*NBITS-1:0] prod;

    // Both operands are sign-extended to full width, so the truncated
    // product is the exact signed product.
    assign weight_ext = {{NBITS{weights[p][NBITS-1]}}, weights[p]};
    assign prod       = weight_ext * feature_ext;
    assign quant[p]   = prod[2*NBITS-1:NBITS];
  end

endmodule

// File: rtl/svm_mac_sequencer.sv
// Streams NFEATURES features, fetches one weight row per feature and
// accumulates the quantized products of NPARALLEL lanes into one result.
module svm_mac_sequencer
  import svm_pkg::*;
#(
  parameter int NBITS     = SVM_NBITS,
  parameter int NPARALLEL = SVM_NPARALLEL,
  parameter int NFEATURES = SVM_NFEATURES,
  parameter int ACCBITS   = NBITS + $clog2(NFEATURES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [NBITS-1:0]               in_feature,
  output logic                                  rom_en,
  output logic [$clog2(NFEATURES)-1:0]          rom_addr,
  input  logic [NPARALLEL-1:0][NBITS-1:0]       rom_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NPARALLEL-1:0][ACCBITS-1:0]     out_acc,
  output logic                                  busy,
  output svm_state_e                            dbg_state
);

  localparam int IW = $clog2(NFEATURES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NFEATURES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high and clear is low; a valid output holds its data until then.

  svm_state_e                        state, state_next;
  logic [IW-1:0]                     idx, idx_next;
  logic signed [NBITS-1:0]           feature;
  logic [NPARALLEL-1:0][ACCBITS-1:0] acc;
  logic [NPARALLEL-1:0][NBITS-1:0]   quant;
  logic                              load_feature;
  logic                              acc_add;
  logic                              acc_zero;

  multiply_quantize #(
    .NBITS     (NBITS),
    .NPARALLEL (NPARALLEL)
  ) u_mq (
    .weights (rom_data),
    .feature (feature),
    .quant   (quant)
  );

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    load_feature = 1'b0;
    acc_add      = 1'b0;
    acc_zero     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    rom_en       = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && !clear && rst_n) begin
          load_feature = 1'b1;
          rom_en       = 1'b1;
          state_next   = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_add = 1'b1;
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          state_next = ST_DONE;
        end else begin
          idx_next   = idx + 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_zero   = 1'b1;
          state_next = ST_LOAD;
        end
      end
      default: state_next = ST_LOAD;
    endcase
    // Abort wins over any handshake; a pending result is simply dropped.
    if (clear) begin
      state_next = ST_LOAD;
      idx_next   = '0;
      acc_zero   = 1'b1;
      acc_add    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_LOAD;
      idx     <= '0;
      feature <= '0;
      acc     <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load_feature) feature <= in_feature;
      if (acc_zero) begin
        acc <= '0;
      end else if (acc_add) begin
        for (int p = 0; p < NPARALLEL; p++) begin
          acc[p] <= acc[p] + {{(ACCBITS-NBITS){quant[p][NBITS-1]}}, quant[p]};
        end
      end
    end
  end

  assign rom_addr  = idx;
  assign out_acc   = acc;
  assign busy      = (idx != '0) || (state != ST_LOAD);
  assign dbg_state = state;

endmodule

// File: doc/svm_mac_sequencer.md
SVM_MAC_SEQUENCER -- requirements
Module: svm_mac_sequencer

Interface
REQ-001 SHALL have parameter NBITS, default 8: signed width of features, weights and quantized products.
REQ-002 SHALL have parameter NPARALLEL, default 4: weight lanes processed per feature.
REQ-003 SHALL have parameter NFEATURES, default 16: features per inference; minimum 2.
REQ-004 SHALL have parameter ACCBITS, default NBITS+$clog2(NFEATURES): signed accumulator width.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have port clear  in  1  synchronous abort of the current inference.
REQ-008 SHALL have port in_valid  in  1  feature available.
REQ-009 SHALL have port in_ready  out  1  sequencer accepts a feature.
REQ-010 SHALL have port in_feature  in  NBITS signed  feature value.
REQ-011 SHALL have port rom_en  out  1  weight-ROM read strobe.
REQ-012 SHALL have port rom_addr  out  $clog2(NFEATURES)  weight-row index.
REQ-013 SHALL have port rom_data  in  NBITS signed x NPARALLEL  weight row, valid one cycle after rom_en.
REQ-014 SHALL have port out_valid  out  1  accumulated result available.
REQ-015 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-016 SHALL have port out_acc  out  ACCBITS signed x NPARALLEL  accumulated results.
REQ-017 SHALL have port busy  out  1  high whenever a feature index other than 0 is pending or state is not LOAD.

Function
REQ-018 SHALL implement FSM states LOAD, MAC and DONE.
REQ-019 In LOAD, in_ready SHALL be 1; all other states SHALL drive in_ready to 0.
REQ-020 In LOAD on in_valid&&in_ready, SHALL latch in_feature, assert rom_en for that cycle with rom_addr=idx, and go to MAC.
REQ-021 rom_en SHALL be 0 in every other cycle; rom_addr SHALL always equal idx.
REQ-022 In MAC, lane p SHALL compute q[p] = bits [2*NBITS-1:NBITS] of signed(rom_data[p]) * signed(feature), i.e. arithmetic shift right by NBITS, truncated to NBITS.
REQ-023 In MAC, acc[p] SHALL be updated to acc[p] + sign-extended q[p], with two's-complement wrap and no saturation.
REQ-024 In MAC with idx<NFEATURES-1, SHALL increment idx and return to LOAD.
REQ-025 In MAC with idx==NFEATURES-1, SHALL set idx=0 and go to DONE.
REQ-026 Each feature SHALL take exactly 2 cycles minimum; an inference SHALL take 2*NFEATURES cycles plus input stalls.
REQ-027 In DONE, out_valid SHALL be 1 and out_acc SHALL equal acc, stable until handshake.
REQ-028 On DONE with out_ready=1, SHALL zero all acc and go to LOAD in the next cycle; out_valid SHALL be 0 in all other states.
REQ-029 With out_ready=0, SHALL hold DONE indefinitely with no change to out_acc.
REQ-030 clear=1 in any state SHALL zero acc and idx and go to LOAD; in_valid is ignored that cycle and the feature is not consumed.
REQ-031 clear SHALL take priority over an in or out handshake in the same cycle; an output withdrawn by clear SHALL be discarded.

Reset
REQ-032 When rst_n=0 at a clock edge, SHALL set state=LOAD, idx=0, all acc=0, and the latched feature to 0.
REQ-033 Reset values SHALL be in_ready=1, out_valid=0, rom_en=0, rom_addr=0, out_acc=0 and busy=0.
REQ-034 Reset SHALL take priority over clear and over all handshakes, including mid-inference.

Structure
REQ-035 Package svm_pkg SHALL hold the FSM state enum and the default NBITS, NPARALLEL and NFEATURES constants.
REQ-036 The lane multiply and quantize SHALL be one instantiated sub-module, multiply_quantize, with NBITS and NPARALLEL passed through.
REQ-037 The sub-module inputs SHALL be rom_data and the latched feature.
REQ-038 Expected RTL size is 120-300 lines.

Verification (NBITS=8, NPARALLEL=2, NFEATURES=3)
REQ-039 Features 64,64,64 with every row {64,-64} -> out_acc={48,-48} and out_valid first high 6 cycles after the first accept.
REQ-040 Feature -128 with row {-128,127}, then two zero features -> out_acc={64,-64}.
REQ-041 Feature -1 with row {1,0}, other features 0 -> out_acc={-1,0}, checking arithmetic-shift truncation.
REQ-042 Hold out_ready=0 for 10 cycles in DONE -> out_acc stable and in_ready=0; then out_ready=1 -> acc cleared and in_ready=1 next cycle.
REQ-043 Assert clear after 2 accepted features -> idx=0 and acc=0; a following full inference gives the same result as from reset.
REQ-044 Drive rst_n=0 while in MAC with in_valid=1 -> all outputs at reset values next cycle and no feature consumed.
